// File: rtl/reduce_arbiter.sv
// reduce_arbiter: round-robin arbiter with per-channel rising-edge event
// latching. Each channel latches a rise of its level request into pending.
// A one-hot grant of fixed length HOLD is issued to one pending channel at a
// time. A rise that lands on an already-pending channel is flagged in the
// sticky overrun bit.
//
// Handshake: grant/active act as the "valid" toward the shared resource and
// busy acts as its "not ready". busy is only looked at in IDLE, where it
// holds off a new grant. Once a grant starts it runs its full HOLD cycles
// regardless of busy. At least one IDLE cycle separates consecutive grants.
module reduce_arbiter #(
  parameter int N    = 4,
  parameter int HOLD = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 busy,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 active,
  output logic [N-1:0]         pending,
  output logic [N-1:0]         overrun
);

  localparam int IW = $clog2(N);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   last_q;
  logic [N-1:0]    grant_q;
  logic [IW-1:0]   gnt_id_q;
  logic            active_q;
  logic [N-1:0]    req_dly_q;
  logic [N-1:0]    pending_q;
  logic [N-1:0]    pending_d;
  logic [N-1:0]    overrun_q;
  logic [N-1:0]    overrun_d;

  logic [N-1:0]    rise;
  logic            win_found;
  logic [IW-1:0]   win_id;
  logic            take;
  logic [N-1:0]    clr_mask;
  int              idx;

  // Rising-edge detect on each request level.
  assign rise = req & ~req_dly_q;

  // Round-robin search upward from the channel after the last winner. Only
  // the registered pending vector is searched, so a rise arriving at this
  // edge is not considered until the next decision.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_q) + k) % N;
      if (!win_found && pending_q[idx]) begin
        win_found = 1'b1;
        win_id    = IW'(idx);
      end
    end
  end

  // A grant is taken only from IDLE, with the resource free and a winner present.
  assign take     = (state_q == IDLE) && !busy && win_found;
  assign clr_mask = take ? ({{(N-1){1'b0}}, 1'b1} << win_id) : '0;

  // Pending and overrun update. A rise on the channel being cleared re-arms
  // pending and is not an overrun.
  always_comb begin
    pending_d = (pending_q & ~clr_mask) | rise;
    overrun_d = overrun_q | (rise & pending_q & ~clr_mask);
  end

  // Event-tracking registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_dly_q <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      req_dly_q <= req;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // Two-state grant FSM with a hold down-counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_q   <= IW'(N - 1);
      grant_q  <= '0;
      gnt_id_q <= '0;
      active_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (take) begin
            state_q  <= GRANT;
            cnt_q    <= CW'(HOLD - 1);
            grant_q  <= clr_mask;
            gnt_id_q <= win_id;
            active_q <= 1'b1;
            last_q   <= win_id;
          end
        end
        GRANT: begin
          if (cnt_q == '0) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gnt_id_q <= '0;
            active_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant   = grant_q;
  assign gnt_id  = gnt_id_q;
  assign active  = active_q;
  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule
